// File: rtl/rv32_instr_encoder.sv
// RV32I instruction encoder: turns a field-level request into machine words.
// Rejected requests produce no output; they raise err_pulse and bump a
// saturating counter instead. LI expands to LUI (+ optional ADDI).
module rv32_instr_encoder #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_kind,
    input  logic [2:0]           req_funct3,
    input  logic                 req_funct7b5,
    input  logic [4:0]           req_rd,
    input  logic [4:0]           req_rs1,
    input  logic [4:0]           req_rs2,
    input  logic [31:0]          req_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_last,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [1:0] {IDLE, EMIT, EMIT2} state_t;

    state_t      state, state_next;
    logic [31:0] word2_q;

    logic signed [31:0] imm_s;
    logic               fits12;
    logic [19:0]        li_hi;
    logic               enc_legal;
    logic               enc_two;
    logic [31:0]        enc_word1;
    logic [31:0]        enc_word2;

    assign imm_s  = req_imm;
    assign fits12 = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
    // (imm + 0x800) >> 12 with wrap: the upper field plus the carry of bit 11
    assign li_hi  = req_imm[31:12] + {19'b0, req_imm[11]};

    // Field-level legality check and word assembly for the presented request
    always_comb begin
        enc_legal = 1'b0;
        enc_two   = 1'b0;
        enc_word1 = 32'b0;
        enc_word2 = 32'b0;
        case (req_kind)
            3'd0: begin
                enc_legal = !req_funct7b5 || (req_funct3 == 3'b000) || (req_funct3 == 3'b101);
                enc_word1 = {1'b0, req_funct7b5, 5'b0, req_rs2, req_rs1, req_funct3, req_rd, OP_R};
            end
            3'd1: begin
                if (req_funct3 == 3'b001 || req_funct3 == 3'b101) begin
                    enc_legal = (req_imm < 32'd32);
                    enc_word1 = {1'b0, req_funct7b5 & (req_funct3 == 3'b101), 5'b0, req_imm[4:0],
                                 req_rs1, req_funct3, req_rd, OP_I};
                end else begin
                    enc_legal = fits12;
                    enc_word1 = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_I};
                end
            end
            3'd2: begin
                enc_legal = fits12 && (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
                enc_word1 = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_LD};
            end
            3'd3: begin
                enc_legal = fits12 && (req_funct3 inside {3'b000, 3'b001, 3'b010});
                enc_word1 = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], OP_ST};
            end
            3'd4: begin
                enc_legal = (req_funct3 != 3'b010) && (req_funct3 != 3'b011) && !req_imm[0]
                            && (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094);
                enc_word1 = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                             req_imm[4:1], req_imm[11], OP_BR};
            end
            3'd5: begin
                enc_legal = (req_imm[11:0] == 12'b0);
                enc_word1 = {req_imm[31:12], req_rd, OP_LUI};
            end
            3'd6: begin
                enc_legal = !req_imm[0] && (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574);
                enc_word1 = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OP_JAL};
            end
            default: begin
                enc_legal = 1'b1;
                if (fits12) begin
                    enc_word1 = {req_imm[11:0], 5'd0, 3'b000, req_rd, OP_I};
                end else begin
                    enc_word1 = {li_hi, req_rd, OP_LUI};
                    enc_two   = (req_imm[11:0] != 12'b0);
                    enc_word2 = {req_imm[11:0], req_rd, 3'b000, req_rd, OP_I};
                end
            end
        endcase
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid && enc_legal) state_next = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = out_last ? IDLE : EMIT2;
            end
            EMIT2: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, output word holding and error accounting
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_instr <= 32'b0;
            out_last  <= 1'b0;
            word2_q   <= 32'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_next;
            err_pulse <= 1'b0;
            if (state == IDLE && req_valid) begin
                if (enc_legal) begin
                    out_instr <= enc_word1;
                    out_last  <= !enc_two;
                    word2_q   <= enc_word2;
                end else begin
                    err_pulse <= 1'b1;
                    if (err_cnt != '1) err_cnt <= err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
                end
            end else if (state == EMIT && out_ready && !out_last) begin
                out_instr <= word2_q;
                out_last  <= 1'b1;
            end
        end
    end

endmodule
